alu_sequencer: RTL

// - Multi-cycle issue/writeback controller on the driving side of the X-Makina ALU.
// - Accepts one register-register or register-immediate ALU instruction at a time over a valid/ready port.
// - Reads operands from the register file and drives the ALU from registered operand/op/status.
// - Captures the ALU result and status, then writes back to the register file and the program status word (PSW).

---
 rtl/xm_pkg.sv | 14 +
 rtl/xm_psw_reg.sv | 16 +
 rtl/alu_sequencer.sv | 104 ++++++++++
 3 files changed

// File: rtl/xm_pkg.sv
// xm_pkg: shared ALU op codes, PSW bit positions, sequencer states and PSW merge helper
package xm_pkg;
  typedef enum logic [3:0] {
    ADD, ADDC, SUB, SUBC, XOR, AND, BIC, BIS, PASS_B, PASS_A, SWPB, SXT
  } alu_op_e;
  localparam int PSW_C = 0;
  localparam int PSW_Z = 1;
  localparam int PSW_N = 2;
  localparam int PSW_V = 3;
  typedef enum logic [2:0] {IDLE, RD_SRC, RD_DST, EXEC, WB} seq_state_e;
  function automatic logic [3:0] psw_merge(input logic [3:0] old, input logic [3:0] st, input logic [3:0] mask);
    return (old & ~mask) | (st & mask);
  endfunction
endpackage

// File: rtl/xm_psw_reg.sv
// xm_psw_reg: 4-bit PSW {V,N,Z,C}; ports clk/rst, i_upd+i_mask+i_st masked update, i_load+i_load_data priority load, o_psw
module xm_psw_reg
  import xm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_upd,
  input  logic [3:0] i_mask,
  input  logic [3:0] i_st,
  input  logic       i_load,
  input  logic [3:0] i_load_data,
  output logic [3:0] o_psw
);
  always_ff @(posedge clk)
    o_psw <= rst ? 4'b0 : i_load ? i_load_data : i_upd ? psw_merge(o_psw, i_st, i_mask) : o_psw;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/writeback FSM for the X-Makina ALU; req_* in, rf_* read/write, registered alu_* drive, psw/psw_load, done pulse
module alu_sequencer
  import xm_pkg::*;
#(
  parameter int WORD = 16,
  parameter int REGS = 8,
  localparam int RA_W = $clog2(REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [RA_W-1:0] req_src,
  input  logic [RA_W-1:0] req_dst,
  input  logic            req_use_imm,
  input  logic [WORD-1:0] req_imm,
  input  logic            req_wb_en,
  input  logic [3:0]      req_psw_mask,
  output logic [RA_W-1:0] rf_raddr,
  input  logic [WORD-1:0] rf_rdata,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [WORD-1:0] rf_wdata,
  output logic [3:0]      alu_op,
  output logic [WORD-1:0] alu_a,
  output logic [WORD-1:0] alu_b,
  output logic [3:0]      alu_status_old,
  input  logic [WORD-1:0] alu_out,
  input  logic [3:0]      alu_status_new,
  output logic [3:0]      psw,
  input  logic            psw_load,
  input  logic [3:0]      psw_load_data,
  output logic            done
);
  seq_state_e      r_state;
  logic [3:0]      r_op;
  logic [RA_W-1:0] r_dst;
  logic            r_wb_en;
  logic [3:0]      r_mask;
  logic [3:0]      r_st;
  assign req_ready      = (r_state == IDLE) && !rst;
  assign alu_status_old = psw;
  // rf_* and done are registered one state ahead so they are high exactly during WB
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      rf_raddr <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      done     <= 1'b0;
    end else begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      done     <= 1'b0;
      case (r_state)
        IDLE: if (req_valid) begin
          r_op     <= req_op;
          r_dst    <= req_dst;
          r_wb_en  <= req_wb_en;
          r_mask   <= req_psw_mask;
          rf_raddr <= req_use_imm ? req_dst : req_src;
          alu_b    <= req_use_imm ? req_imm : alu_b;
          r_state  <= req_use_imm ? RD_DST : RD_SRC;
        end
        RD_SRC: begin
          alu_b    <= rf_rdata;
          rf_raddr <= r_dst;
          r_state  <= RD_DST;
        end
        RD_DST: begin
          alu_a    <= rf_rdata;
          alu_op   <= r_op;
          rf_raddr <= '0;
          r_state  <= EXEC;
        end
        EXEC: begin
          r_st     <= alu_status_new;
          rf_we    <= r_wb_en;
          rf_waddr <= r_dst;
          rf_wdata <= alu_out;
          done     <= 1'b1;
          r_state  <= WB;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  xm_psw_reg u_psw (
    .clk        (clk),
    .rst        (rst),
    .i_upd      (done),
    .i_mask     (r_mask),
    .i_st       (r_st),
    .i_load     (psw_load),
    .i_load_data(psw_load_data),
    .o_psw      (psw)
  );
endmodule
